// File: rtl/fetch_pkg.sv
// Shared constants and the IF/ID payload type for the LEGv8 fetch stage.
package fetch_pkg;
    localparam int XLEN        = 64;
    localparam int ILEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'hD503201F;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } if_id_t;

    localparam if_id_t BUBBLE = '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding slot for an imem response that arrives while decode is stalled.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   drain,
    input  logic   clear,
    input  if_id_t din,
    output logic   valid,
    output if_id_t dout
);

    // clear (redirect) beats load; load and drain never coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= BUBBLE;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, drives a 1-cycle synchronous imem and loads the IF/ID register.
module instruction_fetch_stage
    import fetch_pkg::*;
#(
    parameter int              PC_W      = XLEN,
    parameter int              INSTR_W   = ILEN,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ifid_valid,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [INSTR_W-1:0] ifid_instr
);

    // if_id_t is sized by the package, so PC_W/INSTR_W must match XLEN/ILEN
    localparam if_id_t NOP_SLOT = '{valid: 1'b0, pc: '0, instr: NOP_INSTR};

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] rsp_pc;
    logic            rsp_pending;
    if_id_t          ifid_q;
    if_id_t          rsp;
    if_id_t          skid_q;
    logic            skid_valid;
    logic            advance;
    logic            skid_load;

    assign advance   = !redirect_valid && !stall;
    assign skid_load = !redirect_valid && stall && rsp_pending;
    assign rsp       = '{valid: 1'b1, pc: rsp_pc, instr: imem_rdata};

    // gated by rst_n so no request leaks out while reset is asserted
    assign imem_en   = rst_n && advance;
    assign imem_addr = pc;

    fetch_skid_buf u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .drain (advance && skid_valid),
        .clear (redirect_valid),
        .din   (rsp),
        .valid (skid_valid),
        .dout  (skid_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            rsp_pc      <= '0;
            rsp_pending <= 1'b0;
            ifid_q      <= NOP_SLOT;
        end else if (redirect_valid) begin
            pc          <= {redirect_pc[PC_W-1:2], 2'b00};
            rsp_pending <= 1'b0;
            ifid_q      <= NOP_SLOT;
        end else if (stall) begin
            // a pending response moves into the skid, so it is no longer pending
            rsp_pending <= 1'b0;
        end else begin
            pc          <= pc + PC_W'(INSTR_BYTES);
            rsp_pc      <= pc;
            rsp_pending <= 1'b1;
            if (skid_valid)       ifid_q <= skid_q;
            else if (rsp_pending) ifid_q <= rsp;
            else                  ifid_q <= NOP_SLOT;
        end
    end

    assign ifid_valid = ifid_q.valid;
    assign ifid_pc    = ifid_q.pc;
    assign ifid_instr = ifid_q.instr;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench: directed scenarios then random stall/redirect traffic vs a queue model.
module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_en;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        ifid_valid;
    logic [63:0] ifid_pc;
    logic [31:0] ifid_instr;

    int nvec  = 0;
    int nfail = 0;

    // reference: next fetch address plus the in-order list of fetched-but-undelivered addresses
    logic [63:0] m_pc;
    logic [63:0] inflight[$];
    logic        m_valid;
    logic [63:0] m_ifpc;
    logic [31:0] m_instr;

    always #5 clk = ~clk;

    instruction_fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .ifid_valid     (ifid_valid),
        .ifid_pc        (ifid_pc),
        .ifid_instr     (ifid_instr)
    );

    function automatic logic [31:0] memf(input logic [63:0] a);
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h1234_5678;
    endfunction

    always @(posedge clk) if (imem_en) imem_rdata <= memf(imem_addr);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        inflight.delete();
        m_pc    = '0;
        m_valid = 1'b0;
        m_ifpc  = '0;
        m_instr = NOP;
    endtask

    task automatic check_all(input string tag, input logic en_exp);
        check({tag, ".imem_en"},    64'(imem_en),    64'(en_exp));
        check({tag, ".imem_addr"},  imem_addr,       m_pc);
        check({tag, ".ifid_valid"}, 64'(ifid_valid), 64'(m_valid));
        check({tag, ".ifid_pc"},    ifid_pc,         m_ifpc);
        check({tag, ".ifid_instr"}, 64'(ifid_instr), 64'(m_instr));
    endtask

    // one cycle: drive after negedge, check, clock, advance the model
    task automatic step(input string tag, input logic s, input logic r, input logic [63:0] t);
        stall = s; redirect_valid = r; redirect_pc = t;
        #1;
        check_all(tag, !r && !s);
        @(posedge clk);
        if (r) begin
            inflight.delete();
            m_valid = 1'b0; m_ifpc = '0; m_instr = NOP;
            m_pc = t & ~64'd3;
        end else if (!s) begin
            if (inflight.size() > 0) begin
                m_ifpc = inflight.pop_front();
                m_valid = 1'b1; m_instr = memf(m_ifpc);
            end else begin
                m_valid = 1'b0; m_ifpc = '0; m_instr = NOP;
            end
            inflight.push_back(m_pc);
            m_pc = m_pc + 64'd4;
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        // reset state, with stall low so imem_en must be masked by reset alone
        @(negedge clk);
        check_all("reset", 1'b0);
        rst_n = 1'b1;

        // 1: free-running fetch
        for (int i = 0; i < 3; i++) step("run", 1'b0, 1'b0, '0);
        // 2: stall 3 cycles with a response pending
        for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) step("resume", 1'b0, 1'b0, '0);
        // 3: redirect mid-stream
        step("redir", 1'b0, 1'b1, 64'h40);
        for (int i = 0; i < 4; i++) step("post_redir", 1'b0, 1'b0, '0);
        // 4: redirect and stall together, with the skid loaded first
        step("pre_skid", 1'b1, 1'b0, '0);
        step("skid_held", 1'b1, 1'b0, '0);
        step("redir_stall", 1'b1, 1'b1, 64'h100);
        for (int i = 0; i < 3; i++) step("post_rs", 1'b0, 1'b0, '0);
        // 5: unaligned target, then PC wrap at the top of the address space
        step("redir_43", 1'b0, 1'b1, 64'h43);
        for (int i = 0; i < 2; i++) step("post_43", 1'b0, 1'b0, '0);
        step("redir_top", 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        for (int i = 0; i < 4; i++) step("wrap", 1'b0, 1'b0, '0);

        // 6: async reset mid-stall with the skid occupied
        step("rs_a", 1'b1, 1'b0, '0);
        step("rs_b", 1'b1, 1'b0, '0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst", 1'b0);
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0;
        for (int i = 0; i < 3; i++) step("restart", 1'b0, 1'b0, '0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            logic s, r;
            logic [63:0] t;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 9) == 0);
            t = {32'h0, $urandom()};
            if ($urandom_range(0, 15) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            step("rand", s, r, t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        nfail++;
        $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $fatal(1, "timeout");
    end

endmodule
